// File: rtl/shift_sched_pkg.sv
// Shared types and helpers for the layered-decoding shift sequencer.
package shift_sched_pkg;

   // Sequencer phases: fetch a table entry, wait for its data, issue the
   // relative shift, drain the shifter pipeline, then pulse completion.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      ISSUE,
      DRAIN,
      DONE
   } state_e;

   // Index width for n entries, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Reference form of the cyclic difference (a - b) mod z for a, b < z.
   function automatic int unsigned mod_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned z);
      return (a >= b) ? (a - b) : (a + z - b);
   endfunction

endpackage

// File: rtl/shift_delta_mod.sv
// Combinational cyclic difference (a - b) mod Z for circulant shifts.
// One extra internal bit keeps a + Z - b from wrapping before the subtract.
module shift_delta_mod #(
   parameter int SHARED_BANK_NUM = 255,
   parameter int SHIFT_WIDTH     = $clog2(SHARED_BANK_NUM)
) (
   input  logic [SHIFT_WIDTH-1:0] a_i,
   input  logic [SHIFT_WIDTH-1:0] b_i,
   output logic [SHIFT_WIDTH-1:0] diff_o
);

   localparam logic [SHIFT_WIDTH:0] Z_EXT = (SHIFT_WIDTH+1)'(SHARED_BANK_NUM);

   logic [SHIFT_WIDTH:0] a_ext;
   logic [SHIFT_WIDTH:0] b_ext;
   logic [SHIFT_WIDTH:0] diff_ext;

   assign a_ext = {1'b0, a_i};
   assign b_ext = {1'b0, b_i};

   // Subtract directly when no borrow, otherwise fold back by one circulant.
   always_comb begin
      if (a_ext >= b_ext) begin
         diff_ext = a_ext - b_ext;
      end else begin
         diff_ext = a_ext + Z_EXT - b_ext;
      end
   end

   // Result is always below Z, so the extra bit is zero and drops off here.
   assign diff_o = SHIFT_WIDTH'(diff_ext);

endmodule

// File: rtl/layer_shift_sched.sv
// Shift sequencer: walks iteration/layer/column, turns absolute table shifts
// into shifts relative to the previous layer of the same column, hands them
// to the QSN wrapper over valid/ready and drains its pipeline before done.
module layer_shift_sched
   import shift_sched_pkg::*;
#(
   parameter int SHARED_BANK_NUM = 255,
   parameter int SHIFT_WIDTH     = $clog2(SHARED_BANK_NUM),
   parameter int COL_NUM         = 4,
   parameter int LAYER_NUM       = 3,
   parameter int PIPELINE_STAGE  = 3,
   parameter int ITER_WIDTH      = 5,
   localparam int ADDR_W         = idx_width(LAYER_NUM * COL_NUM),
   localparam int COL_W          = idx_width(COL_NUM)
) (
   input  logic                   sys_clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ITER_WIDTH-1:0]  iter_max,
   output logic                   busy,
   output logic                   done,
   output logic                   tbl_rd_en,
   output logic [ADDR_W-1:0]      tbl_rd_addr,
   input  logic [SHIFT_WIDTH-1:0] tbl_rd_data,
   output logic                   bs_valid,
   input  logic                   bs_ready,
   output logic [SHIFT_WIDTH-1:0] bs_shift,
   output logic [COL_W-1:0]       bs_col
);

   localparam int LAYER_W = idx_width(LAYER_NUM);
   localparam int DRAIN_W = idx_width(PIPELINE_STAGE);

   state_e                 state_q, state_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [LAYER_W-1:0]     layer_q, layer_d;
   logic [ITER_WIDTH-1:0]  iter_q, iter_d;
   logic [ITER_WIDTH-1:0]  iter_max_q, iter_max_d;
   logic [DRAIN_W-1:0]     drain_q, drain_d;
   logic                   clear_prev;

   logic [SHIFT_WIDTH-1:0] prev_q [COL_NUM];
   logic [SHIFT_WIDTH-1:0] bs_shift_q;
   logic [COL_W-1:0]       bs_col_q;
   logic [SHIFT_WIDTH-1:0] delta;

   shift_delta_mod #(
      .SHARED_BANK_NUM (SHARED_BANK_NUM),
      .SHIFT_WIDTH     (SHIFT_WIDTH)
   ) u_delta (
      .a_i    (tbl_rd_data),
      .b_i    (prev_q[col_q]),
      .diff_o (delta)
   );

   // Next-state and counter update; abort overrides every other input.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can
      // leave a signal unassigned and infer a latch.
      state_d    = state_q;
      col_d      = col_q;
      layer_d    = layer_q;
      iter_d     = iter_q;
      iter_max_d = iter_max_q;
      drain_d    = drain_q;
      clear_prev = 1'b0;

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  iter_max_d = iter_max;
                  col_d      = '0;
                  layer_d    = '0;
                  iter_d     = '0;
                  drain_d    = '0;
                  clear_prev = 1'b1;
                  state_d    = (iter_max == '0) ? DONE : FETCH;
               end
            end
            FETCH: state_d = WAIT;
            WAIT:  state_d = ISSUE;
            ISSUE: begin
               if (bs_ready) begin
                  state_d = FETCH;
                  if (col_q == COL_W'(COL_NUM - 1)) begin
                     col_d = '0;
                     if (layer_q == LAYER_W'(LAYER_NUM - 1)) begin
                        layer_d = '0;
                        iter_d  = iter_q + 1'b1;
                        if (iter_q + 1'b1 == iter_max_q) begin
                           state_d = DRAIN;
                           drain_d = '0;
                        end
                     end else begin
                        layer_d = layer_q + 1'b1;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_q == DRAIN_W'(PIPELINE_STAGE - 1)) begin
                  state_d = DONE;
               end else begin
                  drain_d = drain_q + 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and loop counters.
   always_ff @(posedge sys_clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or process order.
      if (!rstn) begin
         state_q    <= IDLE;
         col_q      <= '0;
         layer_q    <= '0;
         iter_q     <= '0;
         iter_max_q <= '0;
         drain_q    <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         layer_q    <= layer_d;
         iter_q     <= iter_d;
         iter_max_q <= iter_max_d;
         drain_q    <= drain_d;
      end
   end

   // Previous-shift history and issued shift; loaded once per element in WAIT.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the history array is reset because the first layer after
         // reset is measured against zero; it is small enough to live in flops.
         for (int i = 0; i < COL_NUM; i++) prev_q[i] <= '0;
         bs_shift_q <= '0;
         bs_col_q   <= '0;
      end else if (clear_prev) begin
         for (int i = 0; i < COL_NUM; i++) prev_q[i] <= '0;
      end else if ((state_q == WAIT) && !abort) begin
         bs_shift_q     <= delta;
         bs_col_q       <= col_q;
         prev_q[col_q]  <= tbl_rd_data;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign tbl_rd_en   = (state_q == FETCH);
   assign bs_valid    = (state_q == ISSUE);
   assign tbl_rd_addr = ADDR_W'(layer_q) * ADDR_W'(COL_NUM) + ADDR_W'(col_q);
   assign bs_shift    = bs_shift_q;
   assign bs_col      = bs_col_q;

endmodule
